// File: rtl/register_pkg.sv
// Shared types for the register writeback path: operand size, queued request,
// and the mapping from an x86 (index, size) pair to a physical register and byte lanes.
package register_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'b00,
    SIZE_WORD  = 2'b01,
    SIZE_DWORD = 2'b10,
    SIZE_RSVD  = 2'b11
  } size_e;

  typedef struct packed {
    logic [2:0]  index;
    size_e       size;
    logic [31:0] data;
  } wb_req_t;

  typedef struct packed {
    logic [2:0] phys;
    logic [3:0] lanes;
  } wb_target_t;

  // Byte encodings 4-7 name AH/CH/DH/BH: lane 1 of registers 0-3.
  function automatic wb_target_t wb_target(input logic [2:0] index, input size_e size);
    wb_target_t t;
    t.phys  = index;
    t.lanes = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        t.phys  = index[2] ? {1'b0, index[1:0]} : index;
        t.lanes = index[2] ? 4'b0010 : 4'b0001;
      end
      SIZE_WORD: t.lanes = 4'b0011;
      default:   t.lanes = 4'b1111;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] lanes);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{lanes[b]}};
    return m;
  endfunction

endpackage

// File: rtl/register_writeback_fifo.sv
// Circular request buffer with wrap-around pointers and an occupancy count.
module register_writeback_fifo
  import register_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  wb_req_t push_data,
  output wb_req_t head,
  output logic    empty,
  output logic    full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t        mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= push_data;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/register_writeback.sv
// Writeback stage: queues sized register writes, merges them into the full 32-bit
// register value and drives the register file write port; exports per-register pending bits.
module register_writeback
  import register_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_index,
  input  logic [1:0]   req_size,
  input  logic [31:0]  req_data,
  input  logic [255:0] gpr_value,
  input  logic         hold,
  input  logic         flush,
  output logic         write_enable,
  output logic [2:0]   write_index,
  output logic [31:0]  write_data,
  output logic [7:0]   pending_mask
);

  // Counters must hold DEPTH queued entries plus the one in the output register.
  localparam int CW = $clog2(DEPTH + 2);

  wb_req_t         in_req, head;
  wb_target_t      in_tgt, head_tgt;
  logic            push, pop, empty, full;
  logic [7:0][31:0] gpr;
  logic [31:0]     base, bits, aligned, merged;

  assign in_req    = '{index: req_index, size: size_e'(req_size), data: req_data};
  assign req_ready = !full;
  assign push      = req_valid && req_ready && !flush;
  assign pop       = !empty && !hold && !flush;

  register_writeback_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (in_req),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  assign in_tgt   = wb_target(req_index, size_e'(req_size));
  assign head_tgt = wb_target(head.index, head.size);
  assign gpr      = gpr_value;

  // The register file only sees the current write at the coming edge, so forward it.
  assign base    = (write_enable && write_index == head_tgt.phys) ? write_data : gpr[head_tgt.phys];
  assign bits    = lane_bits(head_tgt.lanes);
  assign aligned = (head_tgt.lanes == 4'b0010) ? {16'h0, head.data[7:0], 8'h0} : head.data;
  assign merged  = (base & ~bits) | (aligned & bits);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= pop;
      if (pop) begin
        write_index <= head_tgt.phys;
        write_data  <= merged;
      end
    end
  end

  for (genvar r = 0; r < 8; r++) begin : g_pend
    logic [CW-1:0] cnt;
    logic          inc, dec;

    assign inc = push && (in_tgt.phys == 3'(r));
    assign dec = write_enable && (write_index == 3'(r));

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)              cnt <= '0;
      else if (flush)          cnt <= '0;
      else if (inc && !dec)    cnt <= cnt + 1'b1;
      else if (dec && !inc)    cnt <= cnt - 1'b1;
    end

    assign pending_mask[r] = |cnt;
  end

endmodule

// File: tb/tb_register_writeback.sv
// Self-checking bench for register_writeback: directed scenarios plus random traffic
// scored against an in-order architectural model of the register file.
module tb_register_writeback;

  localparam int DEPTH = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_index = '0;
  logic [1:0]   req_size = '0;
  logic [31:0]  req_data = '0;
  logic [255:0] gpr_value;
  logic         hold = 1'b0;
  logic         flush = 1'b0;
  logic         write_enable;
  logic [2:0]   write_index;
  logic [31:0]  write_data;
  logic [7:0]   pending_mask;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  idx;
    logic [1:0]  sz;
    logic [31:0] d;
  } tr_t;

  tr_t         sb [$];
  logic [31:0] rf   [8];
  logic [31:0] arch [8];
  logic        ld_en = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [31:0] ld_val = '0;

  tr_t         mon_t;
  logic [2:0]  mon_p;
  logic [31:0] mon_e;
  logic [7:0]  mon_m;

  register_writeback #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_index    (req_index),
    .req_size     (req_size),
    .req_data     (req_data),
    .gpr_value    (gpr_value),
    .hold         (hold),
    .flush        (flush),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_phys(input logic [2:0] idx, input logic [1:0] sz);
    if (sz == 2'b00 && idx >= 3'd4) return idx - 3'd4;
    return idx;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] b, input tr_t t);
    case (t.sz)
      2'b00:   return (t.idx < 3'd4) ? {b[31:8], t.d[7:0]} : {b[31:16], t.d[7:0], b[7:0]};
      2'b01:   return {b[31:16], t.d[15:0]};
      default: return t.d;
    endcase
  endfunction

  // Register file seen by the DUT.
  always_comb begin
    gpr_value = '0;
    for (int i = 0; i < 8; i++) gpr_value[32*i +: 32] = rf[i];
  end

  always @(posedge clock) begin
    if (ld_en)             rf[ld_idx] <= ld_val;
    else if (write_enable) rf[write_index] <= write_data;
  end

  // Accepted-but-unwritten requests, in acceptance order.
  always @(posedge clock or negedge reset) begin
    if (!reset)                      sb.delete();
    else if (flush)                  sb.delete();
    else if (req_valid && req_ready) sb.push_back('{req_index, req_size, req_data});
  end

  // Each write must be the oldest request applied to the architectural value.
  always @(negedge clock) begin
    if (ld_en) arch[ld_idx] = ld_val;
    if (reset) begin
      mon_m = '0;
      foreach (sb[k]) mon_m[ref_phys(sb[k].idx, sb[k].sz)] = 1'b1;
      chk("mask", 32'(pending_mask), 32'(mon_m));
      if (write_enable) begin
        if (sb.size() == 0) begin
          chk("spurious_we", 32'(write_enable), 32'd0);
        end else begin
          mon_t = sb.pop_front();
          mon_p = ref_phys(mon_t.idx, mon_t.sz);
          mon_e = ref_merge(arch[mon_p], mon_t);
          chk("w_idx", 32'(write_index), 32'(mon_p));
          chk("w_data", write_data, mon_e);
          arch[mon_p] = mon_e;
        end
      end
    end
  end

  task automatic set_reg(input logic [2:0] i, input logic [31:0] v);
    @(negedge clock);
    ld_idx = i; ld_val = v; ld_en = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1 ld_en = 1'b0;
  endtask

  task automatic drive(input logic [2:0] i, input logic [1:0] s, input logic [31:0] d);
    req_valid = 1'b1; req_index = i; req_size = s; req_data = d;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk("rst0_we", 32'(write_enable), 32'd0);
    chk("rst0_idx", 32'(write_index), 32'd0);
    chk("rst0_data", write_data, 32'd0);
    chk("rst0_mask", 32'(pending_mask), 32'd0);
    chk("rst0_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) set_reg(3'(i), $urandom);
    @(negedge clock); #2 reset = 1'b1;

    // AH write: lane 1 of EAX, two cycles after the request is presented
    set_reg(3'd0, 32'h11223344);
    @(negedge clock); drive(3'd4, 2'b00, 32'h000000AB);
    @(negedge clock); req_valid = 1'b0;
    chk("bh_we_early", 32'(write_enable), 32'd0);
    @(negedge clock);
    chk("bh_we", 32'(write_enable), 32'd1);
    chk("bh_idx", 32'(write_index), 32'd0);
    chk("bh_data", write_data, 32'h1122AB44);

    // back-to-back to one register relies on forwarding
    set_reg(3'd0, 32'h0);
    @(negedge clock); drive(3'd0, 2'b01, 32'h0000BEEF);
    @(negedge clock); drive(3'd0, 2'b00, 32'h00000012);
    @(negedge clock); req_valid = 1'b0;
    chk("byp1_data", write_data, 32'h0000BEEF);
    @(negedge clock);
    chk("byp2_we", 32'(write_enable), 32'd1);
    chk("byp2_data", write_data, 32'h0000BE12);
    @(negedge clock);

    // fill while held, then drain in order
    hold = 1'b1;
    @(negedge clock); drive(3'd1, 2'b10, 32'h01010101);
    @(negedge clock); chk("full_rdy1", 32'(req_ready), 32'd1); drive(3'd6, 2'b00, 32'h00000066);
    @(negedge clock); chk("full_rdy2", 32'(req_ready), 32'd0);
    chk("full_mask", 32'(pending_mask), 32'h06);
    drive(3'd3, 2'b01, 32'h00003333);
    @(negedge clock); chk("full_rdy3", 32'(req_ready), 32'd0); hold = 1'b0;
    @(negedge clock); chk("drn1_we", 32'(write_enable), 32'd1);
    chk("drn1_idx", 32'(write_index), 32'd1); chk("drn_rdy", 32'(req_ready), 32'd1);
    @(negedge clock); req_valid = 1'b0;
    chk("drn2_we", 32'(write_enable), 32'd1); chk("drn2_idx", 32'(write_index), 32'd2);
    @(negedge clock); chk("drn3_we", 32'(write_enable), 32'd1); chk("drn3_idx", 32'(write_index), 32'd3);
    @(negedge clock); chk("drn_we_off", 32'(write_enable), 32'd0);
    chk("drn_mask", 32'(pending_mask), 32'd0);

    // flush discards queued work
    hold = 1'b1;
    @(negedge clock); drive(3'd5, 2'b10, 32'h55555555);
    @(negedge clock); drive(3'd0, 2'b01, 32'h0000AAAA);
    @(negedge clock); req_valid = 1'b0; flush = 1'b1;
    chk("fl_mask_pre", 32'(pending_mask), 32'h21);
    @(negedge clock); flush = 1'b0; hold = 1'b0;
    chk("fl_mask", 32'(pending_mask), 32'd0);
    chk("fl_rdy", 32'(req_ready), 32'd1);
    chk("fl_we", 32'(write_enable), 32'd0);
    repeat (3) begin
      @(negedge clock); chk("fl_idle_we", 32'(write_enable), 32'd0);
    end

    // word and reserved-size widths
    set_reg(3'd2, 32'hCAFE0000);
    @(negedge clock); drive(3'd2, 2'b01, 32'hFFFF1234);
    @(negedge clock); drive(3'd7, 2'b11, 32'hDEADBEEF);
    @(negedge clock); req_valid = 1'b0;
    chk("wd_idx", 32'(write_index), 32'd2); chk("wd_data", write_data, 32'hCAFE1234);
    @(negedge clock);
    chk("rs_idx", 32'(write_index), 32'd7); chk("rs_data", write_data, 32'hDEADBEEF);
    @(negedge clock);

    // asynchronous reset while a write is in flight
    @(negedge clock); drive(3'd1, 2'b10, 32'hAAAA5555);
    @(negedge clock); drive(3'd4, 2'b00, 32'h00000077);
    @(negedge clock); req_valid = 1'b0;
    chk("rst_pre_we", 32'(write_enable), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_idx", 32'(write_index), 32'd0);
    chk("rst_data", write_data, 32'd0);
    chk("rst_mask", 32'(pending_mask), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    @(negedge clock); #2 reset = 1'b1;
    repeat (3) begin
      @(negedge clock); chk("rst_idle_we", 32'(write_enable), 32'd0);
    end
    // the dropped write left the model ahead of the register file
    for (int i = 0; i < 8; i++) set_reg(3'(i), $urandom);

    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      req_valid = ($urandom_range(0, 3) != 0);
      req_index = 3'($urandom);
      req_size  = 2'($urandom);
      req_data  = $urandom;
      hold      = ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 39) == 0);
    end
    @(negedge clock);
    req_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge clock);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clock);
    chk("end_mask", 32'(pending_mask), 32'd0);
    chk("end_ready", 32'(req_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
